// File: rtl/rvb_xperm_seq.sv
// rvb_xperm_seq
//   Multi-cycle sequencer for the Zbkx crossbar permutations xperm.n and
//   xperm.b on RV32. It accepts one request over a valid/ready handshake and
//   latches the operands. It then evaluates LANES_PER_CYCLE result lanes per
//   clock. The finished 32-bit result is held until writeback takes it.
//
// Parameters
//   LANES_PER_CYCLE : lanes evaluated per RUN cycle (legal: 1, 2, 4)
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake from execute
//   op_xperm_n          : nibble mode (has priority over op_xperm_b)
//   op_xperm_b          : byte mode
//   rs1                 : lookup table operand
//   rs2                 : index operand
//   flush               : abandons any in-flight request
//   res_valid/res_ready : result handshake to writeback
//   res                 : permutation result
//   busy                : sequencer not idle
module rvb_xperm_seq #(
  parameter int unsigned LANES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op_xperm_n,
  input  logic        op_xperm_b,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_NIB,
    MODE_BYTE
  } mode_t;

  state_t      state;
  state_t      state_nxt;
  mode_t       mode_q;
  mode_t       mode_dec;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] acc_q;
  logic [31:0] acc_nxt;
  logic [31:0] res_q;
  logic [3:0]  lane_cnt;
  logic [3:0]  lane_cnt_nxt;
  logic        lane_last;
  logic        accept;

  // Per-lane scratch used inside the lane-evaluation loop
  logic [2:0]  k;
  logic [4:0]  sh_n;
  logic [4:0]  sh_b;
  logic [3:0]  idx_n;
  logic [7:0]  idx_b;

  always_comb begin
    if (op_xperm_n) begin
      mode_dec = MODE_NIB;
    end else if (op_xperm_b) begin
      mode_dec = MODE_BYTE;
    end else begin
      mode_dec = MODE_NONE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        req_ready = ~reset;
        // A flush in the same cycle kills the request before it is taken
        accept    = req_valid & ~reset & ~flush;
        if (accept) begin
          state_nxt = (mode_dec == MODE_NONE) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (lane_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
    end
  end

  // Lane evaluation: lanes lane_cnt .. lane_cnt+LANES_PER_CYCLE-1.
  // Indices are range-checked on the full lane width, so out-of-range
  // values (nibble 8..15, byte 4..255) yield a zero lane.
  always_comb begin
    acc_nxt = acc_q;
    k       = '0;
    sh_n    = '0;
    sh_b    = '0;
    idx_n   = '0;
    idx_b   = '0;
    for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
      k = lane_cnt[2:0] + 3'(j);
      if (mode_q == MODE_NIB) begin
        sh_n  = {k, 2'b00};
        idx_n = rs2_q[sh_n +: 4];
        if (idx_n[3]) begin
          acc_nxt[sh_n +: 4] = '0;
        end else begin
          acc_nxt[sh_n +: 4] = rs1_q[{idx_n[2:0], 2'b00} +: 4];
        end
      end else if (mode_q == MODE_BYTE) begin
        sh_b  = {k[1:0], 3'b000};
        idx_b = rs2_q[sh_b +: 8];
        if (idx_b < 8'd4) begin
          acc_nxt[sh_b +: 8] = rs1_q[{idx_b[1:0], 3'b000} +: 8];
        end else begin
          acc_nxt[sh_b +: 8] = '0;
        end
      end
    end
  end

  assign lane_cnt_nxt = lane_cnt + 4'(LANES_PER_CYCLE);
  assign lane_last    = (mode_q == MODE_NIB) ? (lane_cnt_nxt >= 4'd8)
                                             : (lane_cnt_nxt >= 4'd4);

  // Operand capture, accumulator and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      mode_q   <= MODE_NONE;
      acc_q    <= '0;
      lane_cnt <= '0;
      res_q    <= '0;
    end else if (accept) begin
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      mode_q   <= mode_dec;
      acc_q    <= '0;
      lane_cnt <= '0;
      if (mode_dec == MODE_NONE) begin
        res_q <= '0;
      end
    end else if (state == ST_RUN && !flush) begin
      acc_q    <= acc_nxt;
      lane_cnt <= lane_cnt_nxt;
      if (lane_last) begin
        res_q <= acc_nxt;
      end
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_rvb_xperm_seq.sv
module tb_rvb_xperm_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_n = 1'b0;
  logic op_b = 1'b0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic flush = 1'b0;
  logic [2:0] req_valid_v = '0;
  logic [2:0] res_ready_v = '0;
  logic [2:0] req_ready_v;
  logic [2:0] res_valid_v;
  logic [2:0] busy_v;
  logic [31:0] res0, res1, res2;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvb_xperm_seq #(.LANES_PER_CYCLE(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .op_xperm_n(op_n), .op_xperm_b(op_b), .rs1(rs1_i), .rs2(rs2_i), .flush(flush),
    .res_valid(res_valid_v[0]), .res_ready(res_ready_v[0]), .res(res0), .busy(busy_v[0])
  );
  rvb_xperm_seq #(.LANES_PER_CYCLE(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .op_xperm_n(op_n), .op_xperm_b(op_b), .rs1(rs1_i), .rs2(rs2_i), .flush(flush),
    .res_valid(res_valid_v[1]), .res_ready(res_ready_v[1]), .res(res1), .busy(busy_v[1])
  );
  rvb_xperm_seq #(.LANES_PER_CYCLE(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .op_xperm_n(op_n), .op_xperm_b(op_b), .rs1(rs1_i), .rs2(rs2_i), .flush(flush),
    .res_valid(res_valid_v[2]), .res_ready(res_ready_v[2]), .res(res2), .busy(busy_v[2])
  );

  typedef struct {
    logic        nib;
    logic        byt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] res_of(int u);
    return (u == 0) ? res0 : (u == 1) ? res1 : res2;
  endfunction

  function automatic int lanes_of(int u);
    return (u == 0) ? 1 : (u == 1) ? 2 : 4;
  endfunction

  // Reference: treat rs1 as a table of n entries of sz bits, rs2 as n indices
  function automatic logic [31:0] ref_xperm(logic nib, logic byt, logic [31:0] a, logic [31:0] b);
    int unsigned sz, n, idx;
    logic [31:0] mask, r;
    r = '0;
    if (nib) sz = 4;
    else if (byt) sz = 8;
    else return 32'h0;
    n = 32 / sz;
    mask = (32'd1 << sz) - 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      idx = (b >> (i * sz)) & mask;
      if (idx < n) r = r | (((a >> (idx * sz)) & mask) << (i * sz));
    end
    return r;
  endfunction

  function automatic int ref_lat(logic nib, logic byt, int l);
    if (!nib && !byt) return 1;
    return (nib ? 8 : 4) / l + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int u, output int cyc);
    cyc = 0;
    while (!res_valid_v[u] && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic transact(input int u, input logic nib, input logic byt,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
    int cyc;
    logic busy_ok;
    op_n = nib; op_b = byt; rs1_i = a; rs2_i = b;
    req_valid_v[u] = 1'b1;
    res_ready_v[u] = 1'b0;
    chk({name, ".req_ready"}, 32'(req_ready_v[u]), 32'd1);
    busy_ok = 1'b1;
    tick();
    cyc = 1;
    // Scramble inputs after accept; the latched operands must be used
    req_valid_v[u] = 1'b0;
    op_n = ~nib; op_b = 1'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    while (!res_valid_v[u] && cyc < 40) begin
      if (!busy_v[u]) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    chk({name, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, ".busy"}, 32'(busy_ok & busy_v[u]), 32'd1);
    chk({name, ".res"}, res_of(u), exp_res);
    res_ready_v[u] = 1'b1;
    tick();
    res_ready_v[u] = 1'b0;
    chk({name, ".idle"}, 32'({res_valid_v[u], busy_v[u], req_ready_v[u]}), 32'b001);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int cyc;
    logic seen;
    logic [3:0] m;
    logic [31:0] a, b;
    int u;

    vt[0] = '{1'b1, 1'b0, 32'h76543210, 32'h01234567, 32'h01234567};
    vt[1] = '{1'b1, 1'b0, 32'hFEDCBA98, 32'h00009F21, 32'h888800A9};
    vt[2] = '{1'b0, 1'b1, 32'hDDCCBBAA, 32'h00010203, 32'hAABBCCDD};
    vt[3] = '{1'b0, 1'b1, 32'hDDCCBBAA, 32'h04FF0100, 32'h0000BBAA};
    vt[4] = '{1'b1, 1'b1, 32'h76543210, 32'h01234567, 32'h01234567};
    vt[5] = '{1'b0, 1'b0, 32'h76543210, 32'h01234567, 32'h00000000};
    vt[6] = '{1'b1, 1'b0, 32'h76543210, 32'h76543210, 32'h76543210};
    vt[7] = '{1'b0, 1'b1, 32'h11223344, 32'h00000000, 32'h44444444};

    // Reset state
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.req_ready%0d", i), 32'(req_ready_v[i]), 32'd0);
      chk($sformatf("reset.res_valid%0d", i), 32'(res_valid_v[i]), 32'd0);
      chk($sformatf("reset.busy%0d", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("reset.res%0d", i), res_of(i), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("reset.release_ready", 32'(req_ready_v), 32'b111);

    // Table vectors on every lane-width variant
    for (int ui = 0; ui < 3; ui++) begin
      for (int i = 0; i < 8; i++) begin
        transact(ui, vt[i].nib, vt[i].byt, vt[i].a, vt[i].b, vt[i].exp,
                 ref_lat(vt[i].nib, vt[i].byt, lanes_of(ui)), $sformatf("vec%0d.L%0d", i, lanes_of(ui)));
      end
    end

    // Backpressure in DONE with a competing request
    op_n = 1'b0; op_b = 1'b1; rs1_i = 32'hDDCCBBAA; rs2_i = 32'h00010203;
    req_valid_v[0] = 1'b1;
    tick();
    req_valid_v[0] = 1'b0;
    wait_valid(0, cyc);
    chk("bp.latency", 32'(cyc + 1), 32'd5);
    op_n = 1'b1; rs1_i = 32'h76543210; rs2_i = 32'h76543210;
    req_valid_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp.res%0d", i), res0, 32'hAABBCCDD);
      chk($sformatf("bp.valid%0d", i), 32'({res_valid_v[0], req_ready_v[0]}), 32'b10);
    end
    req_valid_v[0] = 1'b0;
    res_ready_v[0] = 1'b1;
    tick();
    res_ready_v[0] = 1'b0;
    chk("bp.release", 32'({res_valid_v[0], busy_v[0], req_ready_v[0]}), 32'b001);
    transact(0, 1'b1, 1'b0, 32'h76543210, 32'h01234567, 32'h01234567, 9, "bp.next");

    // Flush at RUN cycle 3, then reset at RUN cycle 3
    for (int pass = 0; pass < 2; pass++) begin
      op_n = 1'b1; op_b = 1'b0; rs1_i = 32'hFEDCBA98; rs2_i = 32'h01234567;
      req_valid_v[0] = 1'b1;
      tick();
      req_valid_v[0] = 1'b0;
      tick(); tick();
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      tick();
      chk($sformatf("kill%0d.state", pass), 32'({res_valid_v[0], busy_v[0]}), 32'b00);
      if (pass == 1) begin
        chk("kill1.req_ready", 32'(req_ready_v[0]), 32'd0);
        chk("kill1.res", res0, 32'd0);
      end
      flush = 1'b0; reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (res_valid_v[0] || busy_v[0]) seen = 1'b1;
      end
      chk($sformatf("kill%0d.quiet", pass), 32'(seen), 32'd0);
      transact(0, 1'b0, 1'b1, 32'hDDCCBBAA, 32'h00010203, 32'hAABBCCDD, 5, $sformatf("kill%0d.next", pass));
    end

    // Flush coincident with a request in IDLE
    op_n = 1'b1; req_valid_v[0] = 1'b1; flush = 1'b1;
    tick();
    req_valid_v[0] = 1'b0; flush = 1'b0;
    chk("flush_req.no_accept", 32'({res_valid_v[0], busy_v[0]}), 32'b00);

    // Flush together with res_ready in DONE
    op_n = 1'b0; op_b = 1'b1; rs1_i = 32'h11223344; rs2_i = 32'h00000102;
    req_valid_v[1] = 1'b1;
    tick();
    req_valid_v[1] = 1'b0;
    wait_valid(1, cyc);
    chk("flush_done.res", res1, 32'h44443322);
    flush = 1'b1; res_ready_v[1] = 1'b1;
    tick();
    flush = 1'b0; res_ready_v[1] = 1'b0;
    chk("flush_done.idle", 32'({res_valid_v[1], busy_v[1], req_ready_v[1]}), 32'b001);

    // Randomized requests against the reference model
    for (int i = 0; i < 60; i++) begin
      u = $urandom_range(0, 2);
      m = 4'($urandom);
      a = $urandom;
      b = $urandom;
      if (m[2]) b = b & 32'h03030303;
      else if (m[3]) b = b & 32'h77777777;
      transact(u, m[0], m[1], a, b, ref_xperm(m[0], m[1], a, b),
               ref_lat(m[0], m[1], lanes_of(u)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
